scr_par_core: RTL and testbench
===============================

// Module: scr_par_core
// PURPOSE
//  Parallel, parametrised scrambler/descrambler core. Processes DATA_WIDTH bits per clock against a configurable
//  LFSR polynomial in additive or self-synchronising mode, with valid/ready flow control, a held seed register and
//  optional periodic reseed. Drop-in successor for the 1-bit scrambler in serial-link TX/RX datapaths.
// PARAMETERS
//  DATA_WIDTH     8        bits per beat; data_in[0] is first in time
//  SCR_WIDTH      7        LFSR length (2..32)
//  POLY           7'h48    tap mask, bit i = tap on s[i]; default x^7+x^4+1
//  MODE           0        0 additive, 1 self-sync scramble, 2 self-sync descramble
//  RESET_SEED     7'h7F    value of seed register and LFSR after kill
//  RESEED_PERIOD  0        beats between automatic LFSR reloads from seed register; 0 disables (max 2^16-1)
// PORTS
//  clk            in   1           clock
//  kill           in   1           synchronous active-high reset
//  scr_en         in   1           1 scramble/descramble, 0 bypass (data unchanged)
//  init_val       in   SCR_WIDTH   new seed
//  init_val_en    in   1           load init_val into seed register and LFSR
//  data_in        in   DATA_WIDTH  input beat
//  data_in_en     in   1           input valid
//  data_in_rdy    out  1           input ready
//  data_out       out  DATA_WIDTH  output beat
//  data_out_en    out  1           output valid
//  data_out_rdy   in   1           downstream ready
//  zero_lock      out  1           LFSR state is all-zero (additive mode stuck)
// BEHAVIOUR
//  Single clock, synchronous active-high reset (kill); no other reset.
//  Reset: seed_reg=LFSR=RESET_SEED, beat_cnt=0, data_out=0, data_out_en=0, zero_lock=0.
//  Bit step k (k=0..DATA_WIDTH-1, applied in order within one beat): fb=^(s & POLY).
//   MODE0: o=d^fb, s<={s[W-2:0],fb}. MODE1: o=d^fb, s<={s,o}. MODE2: o=d^fb, s<={s,d}.
//   In bypass (scr_en=0) o=d, and the LFSR still steps exactly as if scr_en=1.
//  Handshake: beat accepted when data_in_en && data_in_rdy.
//   data_in_rdy = !init_val_en && (!data_out_en || data_out_rdy).
//  Latency 1: an accepted beat appears on data_out at the next edge with data_out_en=1.
//  Output register holds data_out and data_out_en stable until data_out_rdy=1.
//  When data_out is consumed and no new beat is accepted, data_out_en goes to 0 and data_out to 0.
//  Full throughput: 1 beat/clk while data_out_rdy=1.
//  Priority per edge: kill > init_val_en > accepted beat.
//   init_val_en: seed_reg<=init_val, LFSR<=init_val, beat_cnt<=0.
//   No beat is accepted in that cycle; a pending output stays valid.
//  Reseed: beat_cnt counts accepted beats. When RESEED_PERIOD!=0 and the accepted beat makes beat_cnt==RESEED_PERIOD:
//   that beat uses the current LFSR; then LFSR<=seed_reg and beat_cnt<=0.
//  zero_lock: registered, 1 while MODE==0 and LFSR==0.
//   It is informational only; an all-zero LFSR passes data unchanged until reseeded.
//  kill during backpressure drops the held beat (data_out_en=0 next cycle).
// TESTING
//  1. kill, MODE0, default params, data_in=8'h00 x2 with rdy=1 -> data_out 8'h70 then 8'h4F, 1 clk latency each.
//  2. Backpressure: data_out_rdy=0 for 3 clks with a beat pending -> data_out/data_out_en stable, data_in_rdy=0;
//     release -> data delivered once, no beat lost or repeated.
//  3. init_val_en=1 with init_val=7'h7F and data_in_en=1 in the same cycle -> data_in_rdy=0 that cycle;
//     next beat of 8'h00 -> 8'h70.
//  4. RESEED_PERIOD=2, MODE0, zero data: 4 beats -> 70,4F,70,4F.
//  5. MODE1 instance feeding MODE2 instance with mismatched initial seeds, random data:
//     descrambled output equals the source from beat ceil(SCR_WIDTH/DATA_WIDTH)+1 onward.
//  6. init_val=0 in MODE0 -> zero_lock=1, data_out==data_in. scr_en=0 beat -> output equals input and LFSR advances
//     (next scrambled beat matches the reference sequence).

Source files
------------

// File: rtl/scr_par_core_if.sv
// Beat streaming interface for scr_par_core: input beat with valid/ready,
// output beat with valid/ready.
interface scr_par_core_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_en;
    logic                  data_in_rdy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_en;
    logic                  data_out_rdy;

    // Core side: consumes input beats, produces output beats
    modport slave (
        input  data_in,
        input  data_in_en,
        output data_in_rdy,
        output data_out,
        output data_out_en,
        input  data_out_rdy
    );

    // Producer/consumer side wrapped around the core
    modport master (
        output data_in,
        output data_in_en,
        input  data_in_rdy,
        input  data_out,
        input  data_out_en,
        output data_out_rdy
    );
endinterface

// File: rtl/scr_par_core.sv
// Parallel LFSR scrambler/descrambler core. Processes DATA_WIDTH bits per
// beat (data_in[0] first in time) in additive (MODE 0), self-synchronising
// scramble (MODE 1) or self-synchronising descramble (MODE 2) mode, with a
// one-deep registered output stage, a held seed and optional periodic reseed.
module scr_par_core #(
    parameter int                   DATA_WIDTH    = 8,
    parameter int                   SCR_WIDTH     = 7,
    parameter logic [SCR_WIDTH-1:0] POLY          = 7'h48,
    parameter int                   MODE          = 0,
    parameter logic [SCR_WIDTH-1:0] RESET_SEED    = 7'h7F,
    parameter int                   RESEED_PERIOD = 0
) (
    input  logic                 clk,
    input  logic                 kill,
    input  logic                 scr_en,
    input  logic [SCR_WIDTH-1:0] init_val,
    input  logic                 init_val_en,
    scr_par_core_if.slave        bus,
    output logic                 zero_lock
);

    localparam logic [15:0] RESEED_CNT = 16'(RESEED_PERIOD);

    logic [SCR_WIDTH-1:0]  seed_r;
    logic [SCR_WIDTH-1:0]  lfsr_r;
    logic [15:0]           beat_cnt_r;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  data_out_en_r;
    logic                  zero_lock_r;

    logic [SCR_WIDTH-1:0]  step_lfsr_s;
    logic [DATA_WIDTH-1:0] beat_out_s;
    logic                  fb_s;
    logic                  bit_o_s;
    logic                  shift_in_s;
    logic                  rdy_s;
    logic                  accept_s;
    logic                  reseed_hit_s;
    logic [15:0]           cnt_inc_s;
    logic [SCR_WIDTH-1:0]  lfsr_d_s;
    logic [15:0]           cnt_d_s;

    // Feedback bit: parity of the tapped LFSR stages
    function automatic logic tap_parity(input logic [SCR_WIDTH-1:0] s);
        return ^(s & POLY);
    endfunction

    // Unrolled bit-serial walk over one beat; the LFSR steps identically in bypass
    always_comb begin
        step_lfsr_s = lfsr_r;
        beat_out_s  = '0;
        fb_s        = 1'b0;
        bit_o_s     = 1'b0;
        shift_in_s  = 1'b0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            fb_s    = tap_parity(step_lfsr_s);
            bit_o_s = bus.data_in[k] ^ fb_s;
            case (MODE)
                32'sd1:  shift_in_s = bit_o_s;
                32'sd2:  shift_in_s = bus.data_in[k];
                default: shift_in_s = fb_s;
            endcase
            step_lfsr_s = {step_lfsr_s[SCR_WIDTH-2:0], shift_in_s};
            if (scr_en) begin
                beat_out_s[k] = bit_o_s;
            end else begin
                beat_out_s[k] = bus.data_in[k];
            end
        end
    end

    // Handshake and next LFSR/counter state; seed load beats reseed beats beats stepping
    always_comb begin
        rdy_s        = !init_val_en && (!data_out_en_r || bus.data_out_rdy);
        accept_s     = bus.data_in_en && rdy_s;
        cnt_inc_s    = beat_cnt_r + 16'd1;
        reseed_hit_s = (RESEED_CNT != 16'd0) && (cnt_inc_s == RESEED_CNT);
        lfsr_d_s     = lfsr_r;
        cnt_d_s      = beat_cnt_r;
        if (init_val_en) begin
            lfsr_d_s = init_val;
            cnt_d_s  = 16'd0;
        end else if (accept_s) begin
            if (reseed_hit_s) begin
                lfsr_d_s = seed_r;
                cnt_d_s  = 16'd0;
            end else begin
                lfsr_d_s = step_lfsr_s;
                cnt_d_s  = cnt_inc_s;
            end
        end else begin
            lfsr_d_s = lfsr_r;
            cnt_d_s  = beat_cnt_r;
        end
    end

    // State registers and the one-deep output stage
    always_ff @(posedge clk) begin
        if (kill) begin
            seed_r        <= RESET_SEED;
            lfsr_r        <= RESET_SEED;
            beat_cnt_r    <= 16'd0;
            data_out_r    <= '0;
            data_out_en_r <= 1'b0;
            zero_lock_r   <= 1'b0;
        end else begin
            if (init_val_en) begin
                seed_r <= init_val;
            end else begin
                seed_r <= seed_r;
            end
            lfsr_r      <= lfsr_d_s;
            beat_cnt_r  <= cnt_d_s;
            zero_lock_r <= (MODE == 32'sd0) && (lfsr_d_s == '0);
            if (accept_s) begin
                data_out_r    <= beat_out_s;
                data_out_en_r <= 1'b1;
            end else if (bus.data_out_rdy) begin
                data_out_r    <= '0;
                data_out_en_r <= 1'b0;
            end else begin
                data_out_r    <= data_out_r;
                data_out_en_r <= data_out_en_r;
            end
        end
    end

    assign bus.data_in_rdy = rdy_s;
    assign bus.data_out    = data_out_r;
    assign bus.data_out_en = data_out_en_r;
    assign zero_lock       = zero_lock_r;

endmodule

// File: tb/tb_scr_par_core.sv
// Self-checking bench for scr_par_core: directed cases plus a randomized
// scoreboard against a bit-history model of the scrambler recurrence.
module tb_scr_par_core;

    localparam int         W       = 7;
    localparam logic [6:0] TB_POLY = 7'h48;
    localparam logic [6:0] TB_SEED = 7'h7F;

    logic clk;
    logic kill;

    logic       scr_en0, init_val_en0, zl0;
    logic [6:0] init_val0;
    logic       scr_en1, init_val_en1, zl1;
    logic [6:0] init_val1;
    logic       scr_en_a, init_val_en_a, zl_a;
    logic [6:0] init_val_a;
    logic       scr_en_b, init_val_en_b, zl_b;
    logic [6:0] init_val_b;

    scr_par_core_if #(.DATA_WIDTH(8)) bus0 ();
    scr_par_core_if #(.DATA_WIDTH(8)) bus1 ();
    scr_par_core_if #(.DATA_WIDTH(8)) bus_a ();
    scr_par_core_if #(.DATA_WIDTH(8)) bus_b ();

    assign bus_b.data_in      = bus_a.data_out;
    assign bus_b.data_in_en   = bus_a.data_out_en;
    assign bus_a.data_out_rdy = bus_b.data_in_rdy;

    scr_par_core #(.MODE(0)) u_main (
        .clk(clk), .kill(kill), .scr_en(scr_en0), .init_val(init_val0),
        .init_val_en(init_val_en0), .bus(bus0), .zero_lock(zl0));

    scr_par_core #(.MODE(0), .RESEED_PERIOD(2)) u_reseed (
        .clk(clk), .kill(kill), .scr_en(scr_en1), .init_val(init_val1),
        .init_val_en(init_val_en1), .bus(bus1), .zero_lock(zl1));

    scr_par_core #(.MODE(1)) u_scr (
        .clk(clk), .kill(kill), .scr_en(scr_en_a), .init_val(init_val_a),
        .init_val_en(init_val_en_a), .bus(bus_a), .zero_lock(zl_a));

    scr_par_core #(.MODE(2), .RESET_SEED(7'h15)) u_desc (
        .clk(clk), .kill(kill), .scr_en(scr_en_b), .init_val(init_val_b),
        .init_val_en(init_val_en_b), .bus(bus_b), .zero_lock(zl_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_mis = 0;

    // Bit history per model: hist[m][t] is the t-th bit ever shifted into the
    // register (first W entries are the seed, oldest first); the live
    // register occupies hist[m][pos .. pos+W-1].
    logic hist [0:2][0:8191];
    int   pos  [0:2];

    logic       exp_en0;
    logic [7:0] exp_d0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_seed(input int m, input logic [6:0] seed);
        pos[m] = 0;
        for (int t = 0; t < W; t++) hist[m][t] = seed[W-1-t];
    endtask

    task automatic model_beat(input int m, input int mode, input logic scr,
                              input logic [7:0] d, output logic [7:0] o);
        logic fb, ob, nb;
        for (int k = 0; k < 8; k++) begin
            fb = 1'b0;
            for (int i = 0; i < W; i++)
                if (TB_POLY[i]) fb = fb ^ hist[m][pos[m] + W - 1 - i];
            ob = d[k] ^ fb;
            nb = (mode == 0) ? fb : ((mode == 1) ? ob : d[k]);
            hist[m][pos[m] + W] = nb;
            pos[m] = pos[m] + 1;
            o[k] = scr ? ob : d[k];
        end
    endtask

    function automatic logic model_zero(input int m);
        logic z = 1'b1;
        for (int t = 0; t < W; t++) if (hist[m][pos[m] + t]) z = 1'b0;
        return z;
    endfunction

    task automatic do_kill();
        kill = 1'b1;
        bus0.data_in_en = 1'b0; bus0.data_out_rdy = 1'b1; init_val_en0 = 1'b0;
        bus1.data_in_en = 1'b0; bus1.data_out_rdy = 1'b1; init_val_en1 = 1'b0;
        bus_a.data_in_en = 1'b0; bus_b.data_out_rdy = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        model_seed(0, TB_SEED);
        model_seed(2, TB_SEED);
        exp_en0 = 1'b0;
        exp_d0  = 8'h00;
        check_eq("rst_en", {31'd0, bus0.data_out_en}, 32'd0);
        check_eq("rst_data", {24'd0, bus0.data_out}, 32'd0);
        check_eq("rst_zl", {31'd0, zl0}, 32'd0);
    endtask

    // One clock on the main instance, checked against the model
    task automatic cycle0(input logic in_en, input logic [7:0] d, input logic out_rdy,
                          input logic scr, input logic iv_en, input logic [6:0] iv);
        logic       exp_rdy, acc;
        logic [7:0] o;
        bus0.data_in = d; bus0.data_in_en = in_en; bus0.data_out_rdy = out_rdy;
        scr_en0 = scr; init_val_en0 = iv_en; init_val0 = iv;
        #1;
        exp_rdy = !iv_en && (!exp_en0 || out_rdy);
        check_eq("rdy", {31'd0, bus0.data_in_rdy}, {31'd0, exp_rdy});
        acc = in_en && exp_rdy;
        o = 8'h00;
        if (iv_en) model_seed(0, iv);
        else if (acc) model_beat(0, 0, scr, d, o);
        if (acc) begin
            exp_en0 = 1'b1; exp_d0 = o;
        end else if (out_rdy) begin
            exp_en0 = 1'b0; exp_d0 = 8'h00;
        end
        @(posedge clk); #1;
        check_eq("out_en", {31'd0, bus0.data_out_en}, {31'd0, exp_en0});
        check_eq("out_data", {24'd0, bus0.data_out}, {24'd0, exp_d0});
        check_eq("zero_lock", {31'd0, zl0}, {31'd0, model_zero(0)});
    endtask

    logic [7:0] exp4 [4];
    logic [7:0] q_src [$];
    logic [7:0] q_mid [$];

    initial begin
        logic [7:0] d, o, e;
        logic       acc_a, xfer_ab, out_b, rb;
        int         nb;

        kill = 1'b1;
        scr_en0 = 1'b1; init_val0 = 7'h00; init_val_en0 = 1'b0;
        scr_en1 = 1'b1; init_val1 = 7'h00; init_val_en1 = 1'b0;
        scr_en_a = 1'b1; init_val_a = 7'h00; init_val_en_a = 1'b0;
        scr_en_b = 1'b1; init_val_b = 7'h00; init_val_en_b = 1'b0;
        bus0.data_in = 8'h00; bus0.data_in_en = 1'b0; bus0.data_out_rdy = 1'b1;
        bus1.data_in = 8'h00; bus1.data_in_en = 1'b0; bus1.data_out_rdy = 1'b1;
        bus_a.data_in = 8'h00; bus_a.data_in_en = 1'b0; bus_b.data_out_rdy = 1'b1;
        exp4[0] = 8'h70; exp4[1] = 8'h4F; exp4[2] = 8'h70; exp4[3] = 8'h4F;

        // Known additive sequence from the reset seed
        do_kill();
        cycle0(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 7'h00);
        check_eq("t1_beat0", {24'd0, bus0.data_out}, 32'h70);
        cycle0(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 7'h00);
        check_eq("t1_beat1", {24'd0, bus0.data_out}, 32'h4F);

        // Backpressure holds the pending beat, then releases it exactly once
        do_kill();
        cycle0(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 7'h00);
        for (int i = 0; i < 3; i++) cycle0(1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 7'h00);
        cycle0(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 7'h00);
        cycle0(1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 7'h00);
        cycle0(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 7'h00);

        // Seed load blocks the beat in the same cycle
        do_kill();
        cycle0(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 7'h7F);
        cycle0(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 7'h00);
        check_eq("t3_beat", {24'd0, bus0.data_out}, 32'h70);

        // All-zero seed locks; bypass still advances the LFSR
        do_kill();
        cycle0(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 7'h00);
        check_eq("t6_zl_set", {31'd0, zl0}, 32'd1);
        cycle0(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 7'h00);
        check_eq("t6_locked", {24'd0, bus0.data_out}, 32'hA5);
        cycle0(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 7'h7F);
        check_eq("t6_zl_clr", {31'd0, zl0}, 32'd0);
        cycle0(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 7'h00);
        check_eq("t6_bypass", {24'd0, bus0.data_out}, 32'h3C);
        cycle0(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 7'h00);
        check_eq("t6_after", {24'd0, bus0.data_out}, 32'h4F);

        // Randomized traffic on the additive instance
        do_kill();
        for (int i = 0; i < 400; i++) begin
            logic iv_en;
            logic [6:0] iv;
            iv_en = ($urandom_range(0, 19) == 0);
            iv = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom_range(0, 127));
            cycle0(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 6) != 0), iv_en, iv);
        end

        // Periodic reseed every two beats
        do_kill();
        bus1.data_in = 8'h00; bus1.data_in_en = 1'b1; bus1.data_out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("t4_beat%0d", i), {24'd0, bus1.data_out}, {24'd0, exp4[i]});
        end
        bus1.data_in_en = 1'b0;

        // Self-sync scrambler into descrambler with differing seeds
        do_kill();
        nb = 0;
        for (int i = 0; i < 300; i++) begin
            d  = 8'($urandom);
            rb = ($urandom_range(0, 3) != 0);
            bus_a.data_in = d; bus_a.data_in_en = 1'b1; bus_b.data_out_rdy = rb;
            #1;
            acc_a   = bus_a.data_in_rdy;
            xfer_ab = bus_a.data_out_en && bus_b.data_in_rdy;
            out_b   = bus_b.data_out_en && rb;
            if (acc_a) begin
                q_src.push_back(d);
                model_beat(2, 1, 1'b1, d, o);
                q_mid.push_back(o);
            end
            if (xfer_ab) begin
                if (q_mid.size() == 0) check_eq("mid_underflow", 32'd1, 32'd0);
                else begin
                    e = q_mid.pop_front();
                    check_eq("mid", {24'd0, bus_a.data_out}, {24'd0, e});
                end
            end
            if (out_b) begin
                nb++;
                if (q_src.size() == 0) check_eq("chain_underflow", 32'd1, 32'd0);
                else begin
                    e = q_src.pop_front();
                    if (nb >= 2) check_eq("chain", {24'd0, bus_b.data_out}, {24'd0, e});
                end
            end
            @(posedge clk); #1;
        end
        bus_a.data_in_en = 1'b0;
        check_eq("chain_progress", {31'd0, (nb >= 100)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
